median_3x3: RTL and testbench

MEDIAN_3X3 -- requirements
Module: median_3x3

---
 rtl/median_3x3_pkg.sv | 18 +
 rtl/median_3x3_if.sv | 28 ++
 rtl/median_3x3_median9.sv | 39 +++
 rtl/median_3x3.sv | 163 ++++++++++++++++
 tb/tb_median_3x3.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/median_3x3_pkg.sv
// Shared types and constants for the 3x3 median filter.
// Holds the FSM state encoding, pixel width and pipeline depth.
package median_pkg;

  localparam int PIX_W = 8;
  localparam int LAT   = 2;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/median_3x3_if.sv
// Pixel stream bundle between the upstream source and the median filter.
// Master drives pixels in, slave returns filtered pixels and frame end.
interface median_3x3_if;
  import median_pkg::*;

  logic enable;
  pix_t image_input;
  pix_t image_output;
  logic out_valid;
  logic finish;

  modport master (
    output enable,
    output image_input,
    input  image_output,
    input  out_valid,
    input  finish
  );

  modport slave (
    input  enable,
    input  image_input,
    output image_output,
    output out_valid,
    output finish
  );

endinterface

// File: rtl/median_3x3_median9.sv
// Combinational 9-input median: 19 compare-exchange sorting network.
// After the network the 5th smallest value sits in slot 4.
module median9
  import median_pkg::*;
(
  input  logic [8:0][PIX_W-1:0] taps,
  output logic [PIX_W-1:0]      med
);

  localparam logic [4:0] N_CE = 5'd19;

  localparam logic [3:0] LO [19] = '{
    4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd0,
    4'd5, 4'd4, 4'd3, 4'd1, 4'd2, 4'd4, 4'd4, 4'd6, 4'd4
  };

  localparam logic [3:0] HI [19] = '{
    4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8, 4'd3,
    4'd8, 4'd7, 4'd6, 4'd4, 4'd5, 4'd7, 4'd2, 4'd4, 4'd2
  };

  logic [8:0][PIX_W-1:0] v;
  logic [PIX_W-1:0]      t;

  // Each exchange leaves the smaller value in the LO slot.
  always_comb begin
    v = taps;
    t = '0;
    for (logic [4:0] i = 5'd0; i < N_CE; i++) begin
      if (v[LO[i]] > v[HI[i]]) begin
        t        = v[LO[i]];
        v[LO[i]] = v[HI[i]];
        v[HI[i]] = t;
      end
    end
    med = v[4];
  end

endmodule

// File: rtl/median_3x3.sv
// Streaming 3x3 median filter with two line buffers and a 2-stage pipe.
// Border pixels pass through unfiltered; a flush phase drains the frame.
module median_3x3
  import median_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input logic       clk,
  input logic       rst_n,
  median_3x3_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H + 2);
  localparam int FW = $clog2(IMG_W + LAT + 2);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(IMG_H);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [FW-1:0] F_STEPS  = FW'(IMG_W);
  localparam logic [FW-1:0] F_END    = FW'(IMG_W + 1 + LAT);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] fcnt;

  logic accepting;
  logic step;
  logic trig;
  logic border;

  always_comb begin
    accepting = bus.enable &&
                (state == IDLE || state == FILL || state == RUN);
    step      = accepting || (state == FLUSH && fcnt <= F_STEPS);
    trig      = step && (state == RUN || state == FLUSH);
    // The step at (row,col) centres the window on (row-1,col-1).
    border    = col == '0 || col == COL_ONE ||
                row == ROW_ONE || row == ROW_END;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      fcnt       <= '0;
      bus.finish <= 1'b0;
    end else begin
      bus.finish <= 1'b0;
      if (step) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + ROW_ONE;
        end else begin
          col <= col + COL_ONE;
        end
      end
      unique case (state)
        IDLE: if (accepting) state <= FILL;
        FILL: begin
          if (accepting && row == ROW_ONE && col == '0)
            state <= RUN;
        end
        RUN: begin
          if (accepting && row == ROW_LAST && col == COL_LAST) begin
            state <= FLUSH;
            fcnt  <= '0;
          end
        end
        FLUSH: begin
          fcnt <= fcnt + FW'(1);
          if (fcnt == F_END) begin
            state      <= DONE;
            bus.finish <= 1'b1;
            col        <= '0;
            row        <= '0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Each word packs {row-1, row-2} for one column.
  logic [2*PIX_W-1:0] lb [IMG_W];
  logic [2*PIX_W-1:0] rd;

  logic          s0_step;
  logic          s0_trig;
  logic          s0_wr;
  logic          s0_border;
  logic [CW-1:0] s0_col;
  pix_t          s0_pix;
  pix_t          s0_a;
  pix_t          s0_b;

  assign s0_a = rd[2*PIX_W-1:PIX_W];
  assign s0_b = rd[PIX_W-1:0];

  always_ff @(posedge clk) begin
    if (s0_wr) lb[s0_col] <= {s0_pix, s0_a};
    if (step) rd <= lb[col];
  end

  logic [2:0][2:0][PIX_W-1:0] win;
  logic [8:0][PIX_W-1:0]      taps;
  logic                       s1_v;
  logic                       s1_border;
  pix_t                       med;

  assign taps = win;

  always_ff @(posedge clk) begin
    if (step) begin
      s0_pix    <= bus.image_input;
      s0_col    <= col;
      s0_border <= border;
    end
    if (s0_step) begin
      win[0][0] <= win[0][1];
      win[0][1] <= win[0][2];
      win[0][2] <= s0_b;
      win[1][0] <= win[1][1];
      win[1][1] <= win[1][2];
      win[1][2] <= s0_a;
      win[2][0] <= win[2][1];
      win[2][1] <= win[2][2];
      win[2][2] <= s0_pix;
      s1_border <= s0_border;
    end
  end

  median9 u_med (
    .taps (taps),
    .med  (med)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_step          <= 1'b0;
      s0_trig          <= 1'b0;
      s0_wr            <= 1'b0;
      s1_v             <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.image_output <= '0;
    end else begin
      s0_step       <= step;
      s0_trig       <= trig;
      s0_wr         <= accepting;
      s1_v          <= s0_step && s0_trig;
      bus.out_valid <= s1_v;
      if (s1_v)
        bus.image_output <= s1_border ? win[1][1] : med;
    end
  end

endmodule

// File: tb/tb_median_3x3.sv
// Directed bench for median_3x3 on an 8x6 image.
// Scenarios: reset, flat, impulse, border, stalled ramp, abort, back-to-back.
module tb_median_3x3;
  import median_pkg::*;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  median_3x3_if bus ();

  median_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fin_cnt = 0;
  int last_ov = 0;
  int fin_at = 0;
  logic [7:0] outq [$];
  logic [7:0] frm [N];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      outq.push_back(bus.image_output);
      last_ov <= cyc;
    end
    if (bus.finish) begin
      fin_cnt <= fin_cnt + 1;
      fin_at  <= cyc;
    end
  end

  task automatic drive_frame(input bit toggle);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.enable = 1'b1;
      bus.image_input = frm[i];
      if (toggle) begin
        @(negedge clk);
        bus.enable = 1'b0;
        bus.image_input = 8'hAA;
      end
    end
    @(negedge clk);
    bus.enable = 1'b0;
  endtask

  task automatic run_frame(input bit toggle, output bit ok);
    outq.delete();
    drive_frame(toggle);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.finish) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.image_input = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset out_valid: got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.finish !== 1'b0) begin
      n_bad++;
      $display("FAIL reset finish: got %b want 0", bus.finish);
    end
    n_cmp++;
    if (bus.image_output !== 8'd0) begin
      n_bad++;
      $display("FAIL reset image_output: got %0d want 0", bus.image_output);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_constant();
    bit ok;
    int f0;
    foreach (frm[i]) frm[i] = 8'd50;
    f0 = fin_cnt;
    run_frame(1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL const finish_timeout: got none want pulse");
    end
    n_cmp++;
    if (outq.size() !== N) begin
      n_bad++;
      $display("FAIL const count: got %0d want %0d", outq.size(), N);
    end
    for (int i = 0; i < outq.size() && i < N; i++) begin
      n_cmp++;
      if (outq[i] !== 8'd50) begin
        n_bad++;
        $display("FAIL const px%0d: got %0d want 50", i, outq[i]);
      end
    end
    n_cmp++;
    if (fin_cnt - f0 !== 1) begin
      n_bad++;
      $display("FAIL const finishes: got %0d want 1", fin_cnt - f0);
    end
    n_cmp++;
    if (fin_at - last_ov !== 1) begin
      n_bad++;
      $display("FAIL const finish_gap: got %0d want 1", fin_at - last_ov);
    end
  endtask

  task automatic test_impulse();
    bit ok;
    foreach (frm[i]) frm[i] = 8'd0;
    frm[2*W+3] = 8'd255;
    run_frame(1'b0, ok);
    n_cmp++;
    if (!ok || outq.size() !== N) begin
      n_bad++;
      $display("FAIL impulse count: got %0d want %0d (fin %b)",
               outq.size(), N, ok);
    end
    for (int i = 0; i < outq.size() && i < N; i++) begin
      n_cmp++;
      if (outq[i] !== 8'd0) begin
        n_bad++;
        $display("FAIL impulse px%0d: got %0d want 0", i, outq[i]);
      end
    end
  endtask

  task automatic test_border();
    bit ok;
    logic [7:0] exp;
    foreach (frm[i]) frm[i] = 8'd0;
    frm[0*W+4] = 8'd255;
    frm[5*W+7] = 8'd255;
    run_frame(1'b0, ok);
    n_cmp++;
    if (!ok || outq.size() !== N) begin
      n_bad++;
      $display("FAIL border count: got %0d want %0d (fin %b)",
               outq.size(), N, ok);
    end
    for (int i = 0; i < outq.size() && i < N; i++) begin
      exp = (i == 4 || i == 47) ? 8'd255 : 8'd0;
      n_cmp++;
      if (outq[i] !== exp) begin
        n_bad++;
        $display("FAIL border px%0d: got %0d want %0d", i, outq[i], exp);
      end
    end
  endtask

  task automatic test_ramp_stall();
    bit ok;
    int f0;
    foreach (frm[i]) frm[i] = 8'(i);
    f0 = fin_cnt;
    run_frame(1'b1, ok);
    n_cmp++;
    if (!ok || outq.size() !== N) begin
      n_bad++;
      $display("FAIL ramp count: got %0d want %0d (fin %b)",
               outq.size(), N, ok);
    end
    for (int i = 0; i < outq.size() && i < N; i++) begin
      n_cmp++;
      if (outq[i] !== 8'(i)) begin
        n_bad++;
        $display("FAIL ramp px%0d: got %0d want %0d", i, outq[i], i);
      end
    end
    n_cmp++;
    if (fin_cnt - f0 !== 1) begin
      n_bad++;
      $display("FAIL ramp finishes: got %0d want 1", fin_cnt - f0);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int f0;
    f0 = fin_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.enable = 1'b1;
      bus.image_input = 8'd33;
    end
    @(negedge clk);
    bus.enable = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.image_output !== 8'd0) begin
      n_bad++;
      $display("FAIL abort reset_out: got v=%b d=%0d want v=0 d=0",
               bus.out_valid, bus.image_output);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (fin_cnt !== f0) begin
      n_bad++;
      $display("FAIL abort no_finish: got %0d want %0d", fin_cnt, f0);
    end
    foreach (frm[i]) frm[i] = 8'd7;
    run_frame(1'b0, ok);
    n_cmp++;
    if (!ok || outq.size() !== N) begin
      n_bad++;
      $display("FAIL abort count: got %0d want %0d (fin %b)",
               outq.size(), N, ok);
    end
    for (int i = 0; i < outq.size() && i < N; i++) begin
      n_cmp++;
      if (outq[i] !== 8'd7) begin
        n_bad++;
        $display("FAIL abort px%0d: got %0d want 7", i, outq[i]);
      end
    end
    n_cmp++;
    if (fin_cnt - f0 !== 1) begin
      n_bad++;
      $display("FAIL abort finishes: got %0d want 1", fin_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int f0;
    f0 = fin_cnt;
    outq.delete();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      bus.enable = 1'b1;
      bus.image_input = 8'd10;
    end
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      bus.enable = 1'b1;
      bus.image_input = 8'd99;
      if (bus.finish) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok || outq.size() !== N) begin
      n_bad++;
      $display("FAIL b2b_a count: got %0d want %0d (fin %b)",
               outq.size(), N, ok);
    end
    for (int i = 0; i < outq.size() && i < N; i++) begin
      n_cmp++;
      if (outq[i] !== 8'd10) begin
        n_bad++;
        $display("FAIL b2b_a px%0d: got %0d want 10", i, outq[i]);
      end
    end
    foreach (frm[i]) frm[i] = 8'(i);
    run_frame(1'b0, ok);
    n_cmp++;
    if (!ok || outq.size() !== N) begin
      n_bad++;
      $display("FAIL b2b_b count: got %0d want %0d (fin %b)",
               outq.size(), N, ok);
    end
    for (int i = 0; i < outq.size() && i < N; i++) begin
      n_cmp++;
      if (outq[i] !== 8'(i)) begin
        n_bad++;
        $display("FAIL b2b_b px%0d: got %0d want %0d", i, outq[i], i);
      end
    end
    n_cmp++;
    if (fin_cnt - f0 !== 2) begin
      n_bad++;
      $display("FAIL b2b finishes: got %0d want 2", fin_cnt - f0);
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.image_input = 8'h00;
    test_reset();
    test_constant();
    test_impulse();
    test_border();
    test_ramp_stall();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
